// File: rtl/gestor_cubos_pkg.sv
// Shared definitions for the cube-lane path: default lane count and the
// release state machine encoding used by gestor_cubos.
package gestor_cubos_pkg;

  localparam int unsigned ANCHO_CUBOS = 5;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    ESPERA    = 2'd1,
    EMITIENDO = 2'd2
  } estado_t;

endpackage

// File: rtl/fifo_cubos.sv
// Synchronous pattern FIFO with registered occupancy and empty/full flags.
// Pointers wrap naturally because PROFUNDIDAD is a power of two.
module fifo_cubos
  import gestor_cubos_pkg::*;
#(
  parameter int unsigned ANCHO       = ANCHO_CUBOS,
  parameter int unsigned PROFUNDIDAD = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               flush,
  input  logic [ANCHO-1:0]                   din,
  output logic [ANCHO-1:0]                   head,
  output logic [$clog2(PROFUNDIDAD+1)-1:0]   nivel,
  output logic                               vacio,
  output logic                               lleno
);

  localparam int unsigned PW = $clog2(PROFUNDIDAD);
  localparam int unsigned NW = $clog2(PROFUNDIDAD+1);

  logic [ANCHO-1:0] mem_q [PROFUNDIDAD];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]    nivel_q, nivel_d;
  logic             vacio_q, vacio_d;
  logic             lleno_q, lleno_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & ~vacio_q;
    // A push into a full FIFO is legal only when the same-cycle pop frees a slot.
    do_push  = push & (~lleno_q | do_pop);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    nivel_d  = nivel_q + NW'(do_push) - NW'(do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      nivel_d  = '0;
    end
    vacio_d = (nivel_d == '0);
    lleno_d = (nivel_d == NW'(PROFUNDIDAD));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      nivel_q  <= '0;
      vacio_q  <= 1'b1;
      lleno_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      nivel_q  <= nivel_d;
      vacio_q  <= vacio_d;
      lleno_q  <= lleno_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign nivel = nivel_q;
  assign vacio = vacio_q;
  assign lleno = lleno_q;

endmodule

// File: rtl/gestor_cubos.sv
// Buffers nonzero cube-lane patterns and releases one per tick while the game
// runs, holding each released pattern on cubos for DURACION_PULSO cycles.
module gestor_cubos
  import gestor_cubos_pkg::*;
#(
  parameter int unsigned ANCHO          = ANCHO_CUBOS,
  parameter int unsigned PROFUNDIDAD    = 4,
  parameter int unsigned DURACION_PULSO = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [ANCHO-1:0]                   cubos_entrada,
  input  logic                               cubos_valido,
  input  logic                               pulso_habilitador,
  input  logic                               bandera_habilitar_cubos,
  input  logic                               limpiar,
  output logic [ANCHO-1:0]                   cubos,
  output logic                               emitiendo,
  output logic [$clog2(PROFUNDIDAD+1)-1:0]   nivel,
  output logic                               vacio,
  output logic                               lleno,
  output logic                               desbordamiento
);

  localparam int unsigned CW = (DURACION_PULSO > 1) ? $clog2(DURACION_PULSO) : 1;

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] cubos_q, cubos_d;
  logic             emitiendo_q, emitiendo_d;
  logic [CW-1:0]    cuenta_q, cuenta_d;
  logic             desb_q, desb_d;

  logic             escritura, extraer, meter;
  logic [ANCHO-1:0] cabeza;
  logic             fifo_vacio, fifo_lleno;

  assign escritura = cubos_valido & bandera_habilitar_cubos & (|cubos_entrada);
  assign extraer   = (estado_q == ESPERA) & bandera_habilitar_cubos & pulso_habilitador
                     & ~fifo_vacio & ~limpiar;
  assign meter     = escritura & ~limpiar;

  fifo_cubos #(
    .ANCHO       (ANCHO),
    .PROFUNDIDAD (PROFUNDIDAD)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (meter),
    .pop     (extraer),
    .flush   (limpiar),
    .din     (cubos_entrada),
    .head    (cabeza),
    .nivel   (nivel),
    .vacio   (fifo_vacio),
    .lleno   (fifo_lleno)
  );

  always_comb begin
    estado_d    = estado_q;
    cubos_d     = cubos_q;
    emitiendo_d = emitiendo_q;
    cuenta_d    = cuenta_q;
    desb_d      = desb_q | (escritura & fifo_lleno & ~extraer);
    case (estado_q)
      INACTIVO: begin
        cubos_d     = '0;
        emitiendo_d = 1'b0;
        if (bandera_habilitar_cubos) estado_d = ESPERA;
      end
      ESPERA: begin
        if (!bandera_habilitar_cubos) begin
          estado_d = INACTIVO;
        end else if (extraer) begin
          cubos_d     = cabeza;
          emitiendo_d = 1'b1;
          cuenta_d    = CW'(DURACION_PULSO - 1);
          estado_d    = EMITIENDO;
        end
      end
      EMITIENDO: begin
        // Losing the run flag discards the held pattern rather than re-queueing it.
        if (!bandera_habilitar_cubos || cuenta_q == '0) begin
          cubos_d     = '0;
          emitiendo_d = 1'b0;
          estado_d    = bandera_habilitar_cubos ? ESPERA : INACTIVO;
        end else begin
          cuenta_d = cuenta_q - 1'b1;
        end
      end
      default: begin
        cubos_d     = '0;
        emitiendo_d = 1'b0;
        estado_d    = INACTIVO;
      end
    endcase
    if (limpiar) begin
      estado_d    = INACTIVO;
      cubos_d     = '0;
      emitiendo_d = 1'b0;
      cuenta_d    = '0;
      desb_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= INACTIVO;
      cubos_q     <= '0;
      emitiendo_q <= 1'b0;
      cuenta_q    <= '0;
      desb_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cubos_q     <= cubos_d;
      emitiendo_q <= emitiendo_d;
      cuenta_q    <= cuenta_d;
      desb_q      <= desb_d;
    end
  end

  assign cubos          = cubos_q;
  assign emitiendo      = emitiendo_q;
  assign vacio          = fifo_vacio;
  assign lleno          = fifo_lleno;
  assign desbordamiento = desb_q;

endmodule

// File: tb/tb_gestor_cubos.sv
// Self-checking bench for gestor_cubos: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_gestor_cubos;

  localparam int unsigned W = 5;
  localparam int unsigned P = 4;
  localparam int unsigned D = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] cubos_entrada;
  logic         cubos_valido;
  logic         pulso_habilitador;
  logic         bandera_habilitar_cubos;
  logic         limpiar;
  logic [W-1:0] cubos;
  logic         emitiendo;
  logic [2:0]   nivel;
  logic         vacio;
  logic         lleno;
  logic         desbordamiento;
  logic [11:0]  obs;

  int checks   = 0;
  int failures = 0;

  // Reference model state: queued patterns, pattern on display, cycles left to show it.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_show;
  int           m_left;
  bit           m_run;
  bit           m_ov;

  gestor_cubos #(
    .ANCHO          (W),
    .PROFUNDIDAD    (P),
    .DURACION_PULSO (D)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cubos_entrada           (cubos_entrada),
    .cubos_valido            (cubos_valido),
    .pulso_habilitador       (pulso_habilitador),
    .bandera_habilitar_cubos (bandera_habilitar_cubos),
    .limpiar                 (limpiar),
    .cubos                   (cubos),
    .emitiendo               (emitiendo),
    .nivel                   (nivel),
    .vacio                   (vacio),
    .lleno                   (lleno),
    .desbordamiento          (desbordamiento)
  );

  always #5 clk = ~clk;

  assign obs = {cubos, emitiendo, nivel, vacio, lleno, desbordamiento};

  function automatic void model_reset();
    m_q.delete();
    m_show = '0;
    m_left = 0;
    m_run  = 1'b0;
    m_ov   = 1'b0;
  endfunction

  function automatic void model_step();
    bit wr, pop, full;
    if (limpiar) begin
      model_reset();
      return;
    end
    wr   = cubos_valido && bandera_habilitar_cubos && (cubos_entrada != '0);
    full = (m_q.size() == P);
    pop  = 1'b0;
    if (!m_run) begin
      if (bandera_habilitar_cubos) m_run = 1'b1;
    end else if (m_left > 0) begin
      if (!bandera_habilitar_cubos) begin
        m_left = 0;
        m_show = '0;
        m_run  = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) m_show = '0;
      end
    end else if (!bandera_habilitar_cubos) begin
      m_run = 1'b0;
    end else if (pulso_habilitador && m_q.size() > 0) begin
      pop    = 1'b1;
      m_show = m_q.pop_front();
      m_left = D;
    end
    if (wr) begin
      if (!full || pop) m_q.push_back(cubos_entrada);
      else m_ov = 1'b1;
    end
  endfunction

  function automatic logic [11:0] exp_vec();
    return {m_show, (m_left > 0), 3'(m_q.size()), (m_q.size() == 0), (m_q.size() == P), m_ov};
  endfunction

  task automatic cyc(input logic [W-1:0] ent, input logic val, input logic pul,
                     input logic band, input logic lim);
    cubos_entrada           = ent;
    cubos_valido            = val;
    pulso_habilitador       = pul;
    bandera_habilitar_cubos = band;
    limpiar                 = lim;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cubos_entrada = '0; cubos_valido = 0; pulso_habilitador = 0;
    bandera_habilitar_cubos = 0; limpiar = 0;
    model_reset();
    #12;
    checks++;
    if (obs !== {5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset got=%b want=%b", obs, {5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic_release();
    logic [W-1:0] want[4];
    logic [W-1:0] pats[2];
    want = '{5'b00101, 5'b00101, 5'b00101, 5'b00000};
    pats = '{5'b00101, 5'b10000};
    cyc('0, 0, 0, 1, 0);
    cyc(5'b00101, 1, 0, 1, 0);
    cyc(5'b10000, 1, 0, 1, 0);
    checks++;
    if (nivel !== 3'd2) begin
      failures++;
      $display("FAIL basic_level got=%0d want=2", nivel);
    end
    for (int p = 0; p < 2; p++) begin
      want[0] = pats[p]; want[1] = pats[p]; want[2] = pats[p];
      for (int i = 0; i < 4; i++) begin
        cyc('0, 0, (i == 0), 1, 0);
        checks++;
        if (cubos !== want[i] || obs !== exp_vec()) begin
          failures++;
          $display("FAIL basic_release p=%0d i=%0d got=%b/%b want=%b/%b",
                   p, i, cubos, obs, want[i], exp_vec());
        end
      end
    end
    checks++;
    if (vacio !== 1'b1) begin
      failures++;
      $display("FAIL basic_empty got=%b want=1", vacio);
    end
  endtask

  task automatic test_overflow();
    cyc('0, 0, 0, 1, 1);
    for (int v = 1; v <= 5; v++) cyc(5'(v), 1, 0, 1, 0);
    checks++;
    if (lleno !== 1'b1 || nivel !== 3'd4 || desbordamiento !== 1'b1 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL overflow_flags got=lleno%b nivel%0d desb%b want=lleno1 nivel4 desb1",
               lleno, nivel, desbordamiento);
    end
    for (int k = 0; k < 4; k++) begin
      cyc('0, 0, 1, 1, 0);
      checks++;
      if (cubos !== 5'(k + 1) || obs !== exp_vec()) begin
        failures++;
        $display("FAIL overflow_drain k=%0d got=%0d want=%0d", k, cubos, k + 1);
      end
      for (int j = 0; j < 3; j++) cyc('0, 0, 0, 1, 0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL overflow_gap k=%0d got=%b want=%b", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_full_simultaneous();
    logic [W-1:0] order[4];
    order = '{5'd7, 5'd8, 5'd9, 5'b11111};
    cyc('0, 0, 0, 1, 1);
    for (int v = 6; v <= 9; v++) cyc(5'(v), 1, 0, 1, 0);
    cyc(5'b11111, 1, 1, 1, 0);
    checks++;
    if (nivel !== 3'd4 || desbordamiento !== 1'b0 || cubos !== 5'd6 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL full_simul got=nivel%0d desb%b cubos%0d want=nivel4 desb0 cubos6",
               nivel, desbordamiento, cubos);
    end
    for (int j = 0; j < 3; j++) cyc('0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      cyc('0, 0, 1, 1, 0);
      checks++;
      if (cubos !== order[k] || obs !== exp_vec()) begin
        failures++;
        $display("FAIL full_order k=%0d got=%0d want=%0d", k, cubos, order[k]);
      end
      for (int j = 0; j < 3; j++) cyc('0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_zero_and_empty();
    cyc('0, 0, 0, 1, 1);
    cyc('0, 1, 0, 1, 0);
    cyc('0, 1, 0, 1, 0);
    checks++;
    if (nivel !== 3'd0 || vacio !== 1'b1) begin
      failures++;
      $display("FAIL zero_write got=nivel%0d vacio%b want=nivel0 vacio1", nivel, vacio);
    end
    cyc('0, 0, 1, 1, 0);
    checks++;
    if (cubos !== '0 || emitiendo !== 1'b0 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL empty_tick got=cubos%b emit%b want=cubos00000 emit0", cubos, emitiendo);
    end
    cyc(5'b00110, 1, 0, 1, 0);
    cyc('0, 0, 1, 1, 0);
    checks++;
    if (cubos !== 5'b00110 || emitiendo !== 1'b1) begin
      failures++;
      $display("FAIL empty_then_release got=%b want=00110", cubos);
    end
    for (int j = 0; j < 3; j++) cyc('0, 0, 0, 1, 0);
  endtask

  task automatic test_bandera_drop();
    cyc('0, 0, 0, 1, 1);
    cyc(5'b01010, 1, 0, 1, 0);
    cyc(5'b00011, 1, 0, 1, 0);
    cyc(5'b00111, 1, 0, 1, 0);
    cyc('0, 0, 1, 1, 0);
    cyc('0, 0, 0, 1, 0);
    checks++;
    if (cubos !== 5'b01010) begin
      failures++;
      $display("FAIL drop_hold got=%b want=01010", cubos);
    end
    cyc('0, 0, 0, 0, 0);
    checks++;
    if (cubos !== '0 || emitiendo !== 1'b0 || nivel !== 3'd2 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL drop_flag got=cubos%b emit%b nivel%0d want=cubos00000 emit0 nivel2",
               cubos, emitiendo, nivel);
    end
    cyc('0, 0, 0, 1, 0);
    cyc('0, 0, 1, 1, 0);
    checks++;
    if (cubos !== 5'b00011 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL drop_resume got=%b want=00011", cubos);
    end
    for (int j = 0; j < 3; j++) cyc('0, 0, 0, 1, 0);
  endtask

  task automatic test_limpiar();
    cyc('0, 0, 0, 1, 1);
    for (int v = 9; v <= 13; v++) cyc(5'(v), 1, 0, 1, 0);
    cyc('0, 0, 1, 1, 0);
    checks++;
    if (nivel !== 3'd3 || desbordamiento !== 1'b1 || emitiendo !== 1'b1 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL flush_setup got=nivel%0d desb%b emit%b want=nivel3 desb1 emit1",
               nivel, desbordamiento, emitiendo);
    end
    cyc(5'b10101, 1, 1, 1, 1);
    checks++;
    if (obs !== {5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush got=%b want=%b", obs, {5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 1500; n++) begin
      logic [W-1:0] e;
      e = ($urandom_range(0, 4) == 0) ? '0 : 5'($urandom_range(1, 31));
      cyc(e, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        errs++;
        if (errs <= 10) $display("FAIL random n=%0d got=%b want=%b", n, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    cyc('0, 0, 0, 1, 1);
    cyc(5'b11001, 1, 0, 1, 0);
    cyc('0, 0, 1, 1, 0);
    cyc('0, 0, 0, 1, 0);
    checks++;
    if (cubos !== 5'b11001) begin
      failures++;
      $display("FAIL async_setup got=%b want=11001", cubos);
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== {5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got=%b want=%b", obs, {5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc('0, 0, 0, 1, 0);
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL async_after got=%b want=%b", obs, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_basic_release();
    test_overflow();
    test_full_simultaneous();
    test_zero_and_empty();
    test_bandera_drop();
    test_limpiar();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
